// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W     = 16;
  localparam int BEAT_CNT_W = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from last_grant+1.
module fifo_rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic             pick_valid,
  output logic [ID_W-1:0]  pick_id
);

  logic [ID_W-1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(last_grant) + i) % N_REQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter driving a single FIFO write port.
// Optional statistics counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  localparam int ID_W     = id_w(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_W-1:0]             fifo_wr_data,
`ifdef FIFO_ARB_STATS_EN
  input  logic                          stat_clr,
  output logic [N_REQ-1:0][STAT_W-1:0]  stat_beats,
  output logic [STAT_W-1:0]             stat_full_stall,
`endif
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  arb_state_e            state;
  logic [ID_W-1:0]       last_grant;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic                  pick_valid;
  logic [ID_W-1:0]       pick_id;
  logic                  accept;
  logic                  burst_end;

  fifo_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .pick_valid (pick_valid),
    .pick_id    (pick_id)
  );

  assign busy      = (state == BURST);
  assign accept    = busy && req_valid[grant_id] && !fifo_full;
  // A last beat that also hits the burst limit still ends the burst only once.
  assign burst_end = accept &&
                     (req_last[grant_id] || (beat_cnt == BEAT_CNT_W'(MAX_BURST - 1)));

  always_comb begin
    req_ready    = '0;
    fifo_wr_data = '0;
    if (busy) begin
      req_ready[grant_id] = !fifo_full;
      fifo_wr_data        = req_data[grant_id];
    end
  end

  assign fifo_wr_en = accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= BURST;
            grant_id <= pick_id;
          end
        end
        BURST: begin
          if (burst_end) begin
            state      <= IDLE;
            last_grant <= grant_id;
            beat_cnt   <= '0;
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      stat_beats      <= '0;
      stat_full_stall <= '0;
    end else begin
      if (accept) begin
        stat_beats[grant_id] <= sat_inc(stat_beats[grant_id]);
      end
      if (busy && req_valid[grant_id] && fifo_full) begin
        stat_full_stall <= sat_inc(stat_full_stall);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=4); stats checks when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;
  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0][31:0]   req_data;
  logic [N-1:0]         req_last;
  logic [N-1:0]         req_ready;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [31:0]          fifo_wr_data;
  logic [1:0]           grant_id;
  logic                 busy;
`ifdef FIFO_ARB_STATS_EN
  logic                 stat_clr;
  logic [N-1:0][15:0]   stat_beats;
  logic [15:0]          stat_full_stall;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_wr_data    (fifo_wr_data),
`ifdef FIFO_ARB_STATS_EN
    .stat_clr        (stat_clr),
    .stat_beats      (stat_beats),
    .stat_full_stall (stat_full_stall),
`endif
    .grant_id        (grant_id),
    .busy            (busy)
  );

  logic [31:0] qd [N][$];
  bit          ql [N][$];
  bit          src_en [N];
  logic [31:0] wlog[$];
  int          wcyc[$];
  logic [31:0] expq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lcyc;
  logic        s_busy, s_wr;
  logic [1:0]  s_grant;
  logic [N-1:0] s_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = src_en[i] && (qd[i].size() > 0);
      req_data[i]  = (qd[i].size() > 0) ? qd[i][0] : 32'h0;
      req_last[i]  = (ql[i].size() > 0) ? ql[i][0] : 1'b0;
    end
  endtask

  task automatic push(input int id, input logic [31:0] d, input bit last);
    qd[id].push_back(d);
    ql[id].push_back(last);
  endtask

  // Sample at the falling edge, then retire accepted beats just after the rising edge.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc     = req_valid & req_ready;
    s_busy  = busy;
    s_grant = grant_id;
    s_ready = req_ready;
    s_wr    = fifo_wr_en;
    if (fifo_wr_en) begin
      wlog.push_back(fifo_wr_data);
      wcyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      qd[i].delete();
      ql[i].delete();
      src_en[i] = 1'b1;
    end
    drive();
    tick();
    tick();
    rst_n = 1'b1;
    wlog.delete();
    wcyc.delete();
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int k = 0;
    while (wlog.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_count"}, 64'(wlog.size()), 64'(n));
  endtask

  task automatic check_seq(input string tag);
    for (int i = 0; i < expq.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i),
            (i < wlog.size()) ? wlog[i] : 32'hDEAD_BEEF, expq[i]);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif

    // Reset values
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_wr_data", fifo_wr_data, 0);

    // Two pending 3-beat bursts: requester 0 then 2, one bubble between
    lcyc = cyc;
    push(0, 32'h00, 0); push(0, 32'h01, 0); push(0, 32'h02, 1);
    push(2, 32'h20, 0); push(2, 32'h21, 0); push(2, 32'h22, 1);
    drive();
    run_until(6, 30, "t1");
    expq = '{32'h00, 32'h01, 32'h02, 32'h20, 32'h21, 32'h22};
    check_seq("t1_data");
    if (wlog.size() >= 6) begin
      check("t1_latency", 64'(wcyc[0]), 64'(lcyc + 1));
      check("t1_b2b", 64'(wcyc[1] - wcyc[0]), 1);
      check("t1_bubble", 64'(wcyc[3] - wcyc[2]), 2);
    end

    // Continuous bursts without last: forced 4-beat grants rotating 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 8; b++) push(i, 32'(i * 16 + b), 0);
    drive();
    run_until(20, 80, "t2");
    expq.delete();
    for (int g = 0; g < 5; g++)
      for (int b = 0; b < 4; b++) expq.push_back(32'((g % 4) * 16 + ((g == 4) ? 4 : 0) + b));
    check_seq("t2_data");

    // FIFO full for 5 cycles after two beats
    do_reset();
    for (int b = 0; b < 5; b++) push(0, 32'hA0 + 32'(b), b == 4);
    drive();
    run_until(2, 20, "t3_pre");
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_stall_wr_en", s_wr, 0);
      check("t3_stall_ready", s_ready, 0);
      check("t3_stall_busy", s_busy, 1);
    end
    fifo_full = 1'b0;
    run_until(5, 20, "t3");
    expq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
    check_seq("t3_data");

    // Owner drops valid mid-burst; requester 1 must wait
    do_reset();
    for (int b = 0; b < 4; b++) push(0, 32'hB0 + 32'(b), b == 3);
    push(1, 32'hC0, 1);
    drive();
    run_until(1, 20, "t4_pre");
    src_en[0] = 1'b0;
    drive();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_hold_busy", s_busy, 1);
      check("t4_hold_grant", s_grant, 0);
      check("t4_req1_ready", s_ready[1], 0);
      check("t4_hold_wr_en", s_wr, 0);
    end
    src_en[0] = 1'b1;
    drive();
    run_until(5, 20, "t4");
    expq = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hC0};
    check_seq("t4_data");
    if (wlog.size() >= 5) check("t4_single_end", 64'(wcyc[4] - wcyc[3]), 2);

    // Reset during beat 2 of a burst owned by requester 2
    do_reset();
    push(1, 32'hF0, 1);
    drive();
    run_until(1, 10, "t5_pre");
    for (int b = 0; b < 4; b++) push(2, 32'hD0 + 32'(b), b == 3);
    push(0, 32'hE0, 1);
    drive();
    run_until(3, 20, "t5_mid");
    check("t5_req2_won", (wlog.size() >= 2) ? wlog[1] : 32'hDEAD_BEEF, 32'hD0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_grant", grant_id, 0);
    check("t5_rst_ready", req_ready, 0);
    check("t5_rst_wr_en", fifo_wr_en, 0);
    qd[2].delete();
    ql[2].delete();
    wlog.delete();
    wcyc.delete();
    for (int b = 0; b < 4; b++) push(2, 32'hD0 + 32'(b), b == 3);
    drive();
    run_until(5, 30, "t5");
    expq = '{32'hE0, 32'hD0, 32'hD1, 32'hD2, 32'hD3};
    check_seq("t5_data");

`ifdef FIFO_ARB_STATS_EN
    // Statistics: 10 beats from requester 1 with a 3-cycle full stall
    do_reset();
    check("t6_rst_beats1", stat_beats[1], 0);
    check("t6_rst_stall", stat_full_stall, 0);
    for (int b = 0; b < 10; b++) push(1, 32'h100 + 32'(b), b == 9);
    drive();
    run_until(3, 20, "t6_pre");
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    fifo_full = 1'b0;
    run_until(10, 40, "t6");
    check("t6_beats1", stat_beats[1], 10);
    check("t6_beats0", stat_beats[0], 0);
    check("t6_stall", stat_full_stall, 3);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("t6_clr_beats1", stat_beats[1], 0);
    check("t6_clr_stall", stat_full_stall, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
